// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - parametrised 7-segment scan controller with per-digit blink and status outputs
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.

module seg_scan_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int SW_W        = 16,
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2:0]              state_i,
    input  logic [1:0]              clap_state_i,
    input  logic [SW_W-1:0]         sw_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    data_vld_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [6:0]              CAT,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [SW_W-1:0]         LED,
    output logic [2:0]              BGR1,
    output logic [2:0]              BGR2
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [2:0]       LRU_WR   = 3'b010;

    logic [DW-1:0]    r_disp_q;
    logic [SW_W-1:0]  r_sw_q;
    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_idx;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic [6:0]       r_cat;
    logic [NUM_DIGITS-1:0] r_an;
    logic [2:0]       r_bgr1;
    logic [2:0]       r_bgr2;

    logic             w_tick;
    logic [DW-1:0]    w_wr_word;
    logic [DW-1:0]    w_eff;
    logic [3:0]       w_nib;
    logic             w_wr_field;
    logic             w_blink;
    logic             w_lz;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // In write mode the low field of the word is replaced by the live switches
    generate
        if (SW_W < DW) begin : g_wr_partial
            assign w_wr_word = {r_disp_q[DW-1:SW_W], r_sw_q};
        end else begin : g_wr_full
            assign w_wr_word = r_sw_q;
        end
    endgenerate

    assign w_tick     = (r_presc == PRE_LAST);
    assign w_eff      = (state_i == LRU_WR) ? w_wr_word : r_disp_q;
    assign w_nib      = w_eff[{r_idx, 2'b00} +: 4];
    assign w_wr_field = (state_i == LRU_WR) && (32'(r_idx) < SW_W / 4);
    assign w_blink    = r_phase && (blink_mask_i[r_idx] || w_wr_field);

`ifdef SEG_LZB_EN
    logic [IDX_W-1:0] w_msd;

    // Locate the most-significant nonzero digit; an all-zero word leaves digit 0 lit
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_eff[4*i +: 4] != 4'h0) begin
                w_msd = IDX_W'(i);
            end
        end
    end

    assign w_lz = (r_idx > w_msd);
`else
    assign w_lz = 1'b0;
`endif

    // Display word latch and one-cycle capture of switches and status lines
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_disp_q <= '0;
            r_sw_q   <= '0;
            r_bgr1   <= '0;
            r_bgr2   <= '0;
        end else begin
            if (data_vld_i) begin
                r_disp_q <= data_i;
            end
            r_sw_q <= sw_i;
            r_bgr1 <= state_i;
            r_bgr2 <= {1'b0, clap_state_i};
        end
    end

    // Slot prescaler, digit index and blink half-period tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            if (r_blink_cnt == BLK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Registered anode/cathode drive; blanked digits keep their anode active
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_an  <= '1;
            r_cat <= 7'h7F;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_cat <= (w_blink || w_lz) ? 7'h7F : hex7(w_nib);
        end
    end

    assign CAT  = r_cat;
    assign AN   = r_an;
    assign LED  = r_sw_q;
    assign BGR1 = r_bgr1;
    assign BGR2 = r_bgr2;

endmodule
